// File: rtl/composite_fb_reader.sv
// 1bpp 64x64 framebuffer with ping-pong line prefetch feeding the composite timing generator.
// Host byte writes share the single-port RAM with row fetches; pixel output lags (active, xpos, ypos) by 2 cycles.
`timescale 1ns/1ps

// state    | meaning
// ST_IDLE  | no RAM read in flight; host writes may be accepted
// ST_FETCH | reading bytes 0..7 of frow_q, one per cycle
// ST_DONE  | last byte lands, target bank marked valid with its row tag
module composite_fb_reader #(
    parameter int HSTART      = 122,
    parameter int SCALE_SHIFT = 3,
    parameter int MISS_W      = 8
) (
    input  logic              clk10,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [8:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              active,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic              pix,
    output logic              fetch_busy,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam int          SPAN = 64 << SCALE_SHIFT;
    localparam logic [10:0] X_LO = 11'(HSTART);
    localparam logic [10:0] X_HI = 11'(HSTART + SPAN);
    localparam logic [10:0] Y_HI = 11'(SPAN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [5:0]         frow_q, frow_d;
    logic               to_f_q, to_f_d;

    logic [63:0]        f_data_q, f_data_d;
    logic [5:0]         f_tag_q, f_tag_d;
    logic               f_valid_q, f_valid_d;
    logic [63:0]        b_data_q, b_data_d;
    logic [5:0]         b_tag_q, b_tag_d;
    logic               b_valid_q, b_valid_d;

    logic               in_win_s1_q, in_win_s1_d;
    logic [5:0]         col_s1_q, col_s1_d;
    logic [5:0]         row_s1_q, row_s1_d;
    logic               pix_q, pix_d;
    logic [MISS_W-1:0]  miss_q, miss_d;

    logic [7:0]         mem [0:511];
    logic [7:0]         ram_rdata_q;
    logic               ram_we;
    logic [8:0]         ram_addr;

    logic [10:0]        xoff;
    logic               in_window;
    logic [5:0]         next_tag;
    logic               row_event;
    logic               hit;
    logic               fetch_need;
    logic               fetch_start;
    logic               wr_fire;
    logic               st_en;
    logic [2:0]         st_idx;

    assign xoff        = xpos - X_LO;
    assign in_window   = active && (xpos >= X_LO) && (xpos < X_HI) && (ypos < Y_HI);
    assign in_win_s1_d = in_window;
    assign col_s1_d    = 6'(xoff >> SCALE_SHIFT);
    assign row_s1_d    = 6'(ypos >> SCALE_SHIFT);

    assign next_tag = f_tag_q + 6'd1;

    // A miss fetch already heading for this row must not re-trigger every cycle.
    assign row_event = in_win_s1_q
                    && !(f_valid_q && (f_tag_q == row_s1_q))
                    && !((state_q != ST_IDLE) && to_f_q && (frow_q == row_s1_q));
    assign hit       = row_event && b_valid_q && (b_tag_q == row_s1_q);

    assign fetch_need  = !b_valid_q || (f_valid_q && (b_tag_q != next_tag));
    assign fetch_start = (state_q == ST_IDLE) && !row_event && fetch_need;
    assign wr_ready    = (state_q == ST_IDLE) && !fetch_start;
    assign wr_fire     = wr_valid && wr_ready;

    assign fetch_busy = (state_q == ST_FETCH) || (state_q == ST_DONE);
    assign pix        = pix_q;
    assign miss_cnt   = miss_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frow_d    = frow_q;
        to_f_d    = to_f_q;
        f_data_d  = f_data_q;
        f_tag_d   = f_tag_q;
        f_valid_d = f_valid_q;
        b_data_d  = b_data_q;
        b_tag_d   = b_tag_q;
        b_valid_d = b_valid_q;
        miss_d    = miss_q;
        ram_we    = 1'b0;
        ram_addr  = wr_addr;
        st_en     = 1'b0;
        st_idx    = 3'd0;
        pix_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    state_d   = ST_FETCH;
                    idx_d     = 3'd0;
                    frow_d    = f_valid_q ? next_tag : 6'd0;
                    to_f_d    = 1'b0;
                    b_valid_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ram_addr = {frow_q, idx_q};
                idx_d    = idx_q + 3'd1;
                st_en    = (idx_q != 3'd0);
                st_idx   = idx_q - 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                st_en   = 1'b1;
                st_idx  = 3'd7;
                state_d = ST_IDLE;
                if (to_f_q) begin
                    f_valid_d = 1'b1;
                    f_tag_d   = frow_q;
                end else begin
                    b_valid_d = 1'b1;
                    b_tag_d   = frow_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // RAM read data arrives one cycle after its address.
        if (st_en) begin
            if (to_f_q) begin
                f_data_d[{st_idx, 3'b000} +: 8] = ram_rdata_q;
            end else begin
                b_data_d[{st_idx, 3'b000} +: 8] = ram_rdata_q;
            end
        end

        if (row_event) begin
            if (hit) begin
                f_data_d  = b_data_q;
                f_tag_d   = b_tag_q;
                f_valid_d = 1'b1;
                b_data_d  = f_data_q;
                b_tag_d   = f_tag_q;
                b_valid_d = 1'b0;
                if (state_q != ST_IDLE) begin
                    state_d = ST_IDLE;
                end
            end else begin
                if (miss_q != {MISS_W{1'b1}}) begin
                    miss_d = miss_q + MISS_W'(1);
                end
                f_valid_d = 1'b0;
                state_d   = ST_FETCH;
                idx_d     = 3'd0;
                frow_d    = row_s1_q;
                to_f_d    = 1'b1;
            end
        end

        // Patch banks by their post-swap role so a write never goes stale.
        if (wr_fire) begin
            ram_we = 1'b1;
            if (f_valid_d && (f_tag_d == wr_addr[8:3])) begin
                f_data_d[{wr_addr[2:0], 3'b000} +: 8] = wr_data;
            end
            if (b_valid_d && (b_tag_d == wr_addr[8:3])) begin
                b_data_d[{wr_addr[2:0], 3'b000} +: 8] = wr_data;
            end
        end

        pix_d = in_win_s1_q && f_valid_d && f_data_d[{col_s1_q[5:3], ~col_s1_q[2:0]}];
    end

    always_ff @(posedge clk10) begin
        if (ram_we) begin
            mem[ram_addr] <= wr_data;
        end
        ram_rdata_q <= mem[ram_addr];
    end

    always_ff @(posedge clk10 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            frow_q      <= 6'd0;
            to_f_q      <= 1'b0;
            f_data_q    <= 64'd0;
            f_tag_q     <= 6'd0;
            f_valid_q   <= 1'b0;
            b_data_q    <= 64'd0;
            b_tag_q     <= 6'd0;
            b_valid_q   <= 1'b0;
            in_win_s1_q <= 1'b0;
            col_s1_q    <= 6'd0;
            row_s1_q    <= 6'd0;
            pix_q       <= 1'b0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frow_q      <= frow_d;
            to_f_q      <= to_f_d;
            f_data_q    <= f_data_d;
            f_tag_q     <= f_tag_d;
            f_valid_q   <= f_valid_d;
            b_data_q    <= b_data_d;
            b_tag_q     <= b_tag_d;
            b_valid_q   <= b_valid_d;
            in_win_s1_q <= in_win_s1_d;
            col_s1_q    <= col_s1_d;
            row_s1_q    <= row_s1_d;
            pix_q       <= pix_d;
            miss_q      <= miss_d;
        end
    end

endmodule
